// File: rtl/dm_arbiter.sv
// Two-port load/store arbiter in front of the data memory: grants A or B, drives
// word address, byte enables and store data, and returns aligned/extended load data.
module dm_arbiter #(
  parameter int ADDR_W     = 12,
  parameter bit PRIO_FIXED = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [1:0]        a_size,
  input  logic              a_sign,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [31:0]       a_wdata,
  output logic              a_done,
  output logic              a_err,
  output logic [31:0]       a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [1:0]        b_size,
  input  logic              b_sign,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [31:0]       b_wdata,
  output logic              b_done,
  output logic              b_err,
  output logic [31:0]       b_rdata,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_din,
  output logic              mem_we,
  input  logic [31:0]       mem_dout,
  output logic              busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              last_b_q, gnt_b_q;
  logic              we_q, sign_q, err_q;
  logic [1:0]        size_q, lane_q;
  logic [ADDR_W-3:0] mem_addr_q;
  logic [3:0]        mem_be_q;
  logic [31:0]       mem_din_q;
  logic              mem_we_q;
  logic              a_done_q, a_err_q, b_done_q, b_err_q;
  logic [31:0]       a_rdata_q, b_rdata_q;

  logic              sel_b;
  logic              sel_we, sel_sign, sel_err;
  logic [1:0]        sel_size;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic [31:0]       load_val;

  function automatic logic size_err(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'b00:   return 1'b0;
      2'b01:   return lane[0];
      2'b10:   return lane != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] lane,
                                        input logic err);
    if (err) return 4'b0000;
    case (size)
      2'b00:   return 4'b0001 << lane;
      2'b01:   return lane[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] load_fmt(input logic [31:0] dout, input logic [1:0] size,
                                           input logic sign, input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = dout[7:0];
      2'd1:    b = dout[15:8];
      2'd2:    b = dout[23:16];
      default: b = dout[31:24];
    endcase
    h = lane[1] ? dout[31:16] : dout[15:0];
    case (size)
      2'b00:   return {{24{sign & b[7]}}, b};
      2'b01:   return {{16{sign & h[15]}}, h};
      default: return dout;
    endcase
  endfunction

  // Tie-break: fixed mode always favours A, otherwise whoever was not served last.
  always_comb begin
    sel_b     = b_req && (!a_req || (!PRIO_FIXED && !last_b_q));
    sel_we    = sel_b ? b_we    : a_we;
    sel_size  = sel_b ? b_size  : a_size;
    sel_sign  = sel_b ? b_sign  : a_sign;
    sel_addr  = sel_b ? b_addr  : a_addr;
    sel_wdata = sel_b ? b_wdata : a_wdata;
    sel_err   = size_err(sel_size, sel_addr[1:0]);
    load_val  = (err_q || we_q) ? 32'h0 : load_fmt(mem_dout, size_q, sign_q, lane_q);
    state_d   = state_q;
    case (state_q)
      S_IDLE:   if (a_req || b_req) state_d = S_ACCESS;
      S_ACCESS: state_d = S_DONE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      last_b_q   <= 1'b1;
      gnt_b_q    <= 1'b0;
      we_q       <= 1'b0;
      sign_q     <= 1'b0;
      err_q      <= 1'b0;
      size_q     <= 2'b00;
      lane_q     <= 2'b00;
      mem_addr_q <= '0;
      mem_be_q   <= 4'b0000;
      mem_din_q  <= 32'h0;
      mem_we_q   <= 1'b0;
      a_done_q   <= 1'b0;
      a_err_q    <= 1'b0;
      a_rdata_q  <= 32'h0;
      b_done_q   <= 1'b0;
      b_err_q    <= 1'b0;
      b_rdata_q  <= 32'h0;
    end else begin
      state_q  <= state_d;
      a_done_q <= 1'b0;
      b_done_q <= 1'b0;
      mem_we_q <= 1'b0;
      mem_be_q <= 4'b0000;
      case (state_q)
        S_IDLE: begin
          if (a_req || b_req) begin
            gnt_b_q    <= sel_b;
            last_b_q   <= sel_b;
            we_q       <= sel_we;
            size_q     <= sel_size;
            sign_q     <= sel_sign;
            lane_q     <= sel_addr[1:0];
            err_q      <= sel_err;
            mem_addr_q <= sel_addr[ADDR_W-1:2];
            mem_din_q  <= sel_wdata;
            mem_be_q   <= be_gen(sel_size, sel_addr[1:0], sel_err);
            mem_we_q   <= sel_we && !sel_err;
          end
        end
        // Memory read data is combinational on mem_addr, so it is captured here.
        S_ACCESS: begin
          if (gnt_b_q) begin
            b_done_q  <= 1'b1;
            b_err_q   <= err_q;
            b_rdata_q <= load_val;
          end else begin
            a_done_q  <= 1'b1;
            a_err_q   <= err_q;
            a_rdata_q <= load_val;
          end
        end
        default: ;
      endcase
    end
  end

  assign a_done   = a_done_q;
  assign a_err    = a_err_q;
  assign a_rdata  = a_rdata_q;
  assign b_done   = b_done_q;
  assign b_err    = b_err_q;
  assign b_rdata  = b_rdata_q;
  assign mem_addr = mem_addr_q;
  assign mem_be   = mem_be_q;
  assign mem_din  = mem_din_q;
  assign mem_we   = mem_we_q;
  assign busy     = state_q != S_IDLE;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter: vector table for lane/extend/error behaviour,
// hand sequences for arbitration, late requests and reset.
module tb_dm_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_req = 0, a_we = 0, a_sign = 0;
  logic [1:0]  a_size = 0;
  logic [11:0] a_addr = 0;
  logic [31:0] a_wdata = 0;
  logic        b_req = 0, b_we = 0, b_sign = 0;
  logic [1:0]  b_size = 0;
  logic [11:0] b_addr = 0;
  logic [31:0] b_wdata = 0;
  logic        a_done, a_err, b_done, b_err, mem_we, busy;
  logic [31:0] a_rdata, b_rdata, mem_din, mem_dout;
  logic [9:0]  mem_addr;
  logic [3:0]  mem_be;

  logic        p_a_req = 0, p_b_req = 0;
  logic        p_zero1 = 0;
  logic [1:0]  p_size = 2'b10;
  logic [11:0] p_addr = 0;
  logic [31:0] p_zero32 = 0;
  logic        p_a_done, p_a_err, p_b_done, p_b_err, p_mem_we, p_busy;
  logic [31:0] p_a_rdata, p_b_rdata, p_mem_din;
  logic [9:0]  p_mem_addr;
  logic [3:0]  p_mem_be;

  logic [31:0] mem [0:1023];
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dm_arbiter #(.ADDR_W(12), .PRIO_FIXED(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_size(a_size), .a_sign(a_sign), .a_addr(a_addr),
    .a_wdata(a_wdata), .a_done(a_done), .a_err(a_err), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_size(b_size), .b_sign(b_sign), .b_addr(b_addr),
    .b_wdata(b_wdata), .b_done(b_done), .b_err(b_err), .b_rdata(b_rdata),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_din(mem_din), .mem_we(mem_we),
    .mem_dout(mem_dout), .busy(busy));

  dm_arbiter #(.ADDR_W(12), .PRIO_FIXED(1'b1)) dut_fixed (
    .clk(clk), .rst_n(rst_n),
    .a_req(p_a_req), .a_we(p_zero1), .a_size(p_size), .a_sign(p_zero1), .a_addr(p_addr),
    .a_wdata(p_zero32), .a_done(p_a_done), .a_err(p_a_err), .a_rdata(p_a_rdata),
    .b_req(p_b_req), .b_we(p_zero1), .b_size(p_size), .b_sign(p_zero1), .b_addr(p_addr),
    .b_wdata(p_zero32), .b_done(p_b_done), .b_err(p_b_err), .b_rdata(p_b_rdata),
    .mem_addr(p_mem_addr), .mem_be(p_mem_be), .mem_din(p_mem_din), .mem_we(p_mem_we),
    .mem_dout(p_zero32), .busy(p_busy));

  // Memory model: store data arrives right-justified and is steered to the enabled lanes.
  assign mem_dout = mem[mem_addr];
  always @(negedge clk) begin
    if (mem_we) begin
      case (mem_be)
        4'b0001: mem[mem_addr][7:0]   <= mem_din[7:0];
        4'b0010: mem[mem_addr][15:8]  <= mem_din[7:0];
        4'b0100: mem[mem_addr][23:16] <= mem_din[7:0];
        4'b1000: mem[mem_addr][31:24] <= mem_din[7:0];
        4'b0011: mem[mem_addr][15:0]  <= mem_din[15:0];
        4'b1100: mem[mem_addr][31:16] <= mem_din[15:0];
        4'b1111: mem[mem_addr]        <= mem_din;
        default: ;
      endcase
    end
  end

  typedef struct {
    logic        port;
    logic        we;
    logic [1:0]  size;
    logic        sign;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [3:0]  be;
    logic [31:0] rdata;
  } vec_t;

  vec_t vt[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_done(input int bound, output int who, output int n);
    who = 0;
    n = 0;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk); #1;
      n++;
      if (a_done || b_done) begin
        who = {30'b0, b_done, a_done};
        break;
      end
    end
  endtask

  task automatic wait_done_p(input int bound, output int who);
    who = 0;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk); #1;
      if (p_a_done || p_b_done) begin
        who = {30'b0, p_b_done, p_a_done};
        break;
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    if (v.port) begin
      b_we = v.we; b_size = v.size; b_sign = v.sign; b_addr = v.addr; b_wdata = v.wdata;
      b_req = 1'b1;
    end else begin
      a_we = v.we; a_size = v.size; a_sign = v.sign; a_addr = v.addr; a_wdata = v.wdata;
      a_req = 1'b1;
    end
    @(posedge clk); #1;
    chk($sformatf("v%0d_busy", idx), {31'b0, busy}, 32'd1);
    chk($sformatf("v%0d_addr", idx), {22'b0, mem_addr}, {22'b0, v.addr[11:2]});
    chk($sformatf("v%0d_be", idx), {28'b0, mem_be}, {28'b0, v.be});
    chk($sformatf("v%0d_we", idx), {31'b0, mem_we}, {31'b0, v.we & ~v.err});
    chk($sformatf("v%0d_din", idx), mem_din, v.wdata);
    @(posedge clk); #1;
    chk($sformatf("v%0d_done", idx), {30'b0, b_done, a_done}, v.port ? 32'd2 : 32'd1);
    chk($sformatf("v%0d_dbe", idx), {27'b0, mem_we, mem_be}, 32'd0);
    chk($sformatf("v%0d_err", idx), {31'b0, v.port ? b_err : a_err}, {31'b0, v.err});
    if (!v.we) chk($sformatf("v%0d_rdata", idx), v.port ? b_rdata : a_rdata, v.rdata);
    a_req = 1'b0;
    b_req = 1'b0;
    @(posedge clk); #1;
    chk($sformatf("v%0d_idle", idx), {30'b0, busy, a_done | b_done}, 32'd0);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_ctl"}, {26'b0, a_done, a_err, b_done, b_err, mem_we, busy}, 32'd0);
    chk({nm, "_be"}, {28'b0, mem_be}, 32'd0);
    chk({nm, "_maddr"}, {22'b0, mem_addr}, 32'd0);
    chk({nm, "_din"}, mem_din, 32'd0);
    chk({nm, "_ard"}, a_rdata, 32'd0);
    chk({nm, "_brd"}, b_rdata, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int who, n;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    //           port we  size  sign addr    wdata         err  be       rdata
    vt[0]  = '{1'b0, 1'b1, 2'b10, 1'b0, 12'h010, 32'hDEADBEEF, 1'b0, 4'b1111, 32'h0};
    vt[1]  = '{1'b0, 1'b0, 2'b10, 1'b0, 12'h010, 32'h0,        1'b0, 4'b1111, 32'hDEADBEEF};
    vt[2]  = '{1'b0, 1'b1, 2'b00, 1'b0, 12'h013, 32'h00000080, 1'b0, 4'b1000, 32'h0};
    vt[3]  = '{1'b0, 1'b0, 2'b00, 1'b1, 12'h013, 32'h0,        1'b0, 4'b1000, 32'hFFFFFF80};
    vt[4]  = '{1'b0, 1'b0, 2'b00, 1'b0, 12'h013, 32'h0,        1'b0, 4'b1000, 32'h00000080};
    vt[5]  = '{1'b0, 1'b1, 2'b01, 1'b0, 12'h012, 32'h00008001, 1'b0, 4'b1100, 32'h0};
    vt[6]  = '{1'b1, 1'b0, 2'b01, 1'b1, 12'h012, 32'h0,        1'b0, 4'b1100, 32'hFFFF8001};
    vt[7]  = '{1'b1, 1'b0, 2'b01, 1'b0, 12'h010, 32'h0,        1'b0, 4'b0011, 32'h0000BEEF};
    vt[8]  = '{1'b0, 1'b0, 2'b00, 1'b1, 12'h011, 32'h0,        1'b0, 4'b0010, 32'hFFFFFFBE};
    vt[9]  = '{1'b0, 1'b1, 2'b10, 1'b0, 12'h006, 32'h12345678, 1'b1, 4'b0000, 32'h0};
    vt[10] = '{1'b0, 1'b1, 2'b01, 1'b0, 12'h001, 32'h00001111, 1'b1, 4'b0000, 32'h0};
    vt[11] = '{1'b0, 1'b0, 2'b11, 1'b0, 12'h020, 32'h0,        1'b1, 4'b0000, 32'h0};
    vt[12] = '{1'b1, 1'b0, 2'b10, 1'b1, 12'h010, 32'h0,        1'b0, 4'b1111, 32'h8001BEEF};
    vt[13] = '{1'b0, 1'b0, 2'b00, 1'b0, 12'h010, 32'h0,        1'b0, 4'b0001, 32'h000000EF};

    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) run_vec(vt[i], i);
    chk("misaligned_mem_unchanged", mem[1], 32'h0);
    chk("half_err_mem_unchanged", mem[0], 32'h0);

    // Tie from reset: A first, then B.
    rst_n = 1'b0; @(posedge clk); #1; rst_n = 1'b1;
    a_we = 0; a_size = 2'b10; a_addr = 12'h010;
    b_we = 0; b_size = 2'b10; b_addr = 12'h010;
    a_req = 1; b_req = 1;
    wait_done(6, who, n);
    chk("tie_first", who, 32'd1);
    chk("tie_latency", n, 32'd2);
    a_req = 0;
    wait_done(6, who, n);
    chk("tie_second", who, 32'd2);
    chk("tie_b_rdata", b_rdata, 32'h8001BEEF);
    b_req = 0;
    @(posedge clk); #1;

    // Both held: round-robin alternation at one access per three cycles.
    a_req = 1; b_req = 1;
    for (int k = 0; k < 4; k++) begin
      wait_done(8, who, n);
      chk($sformatf("rr_grant%0d", k), who, (k % 2 == 1) ? 32'd2 : 32'd1);
      if (k > 0) chk($sformatf("rr_spacing%0d", k), n, 32'd3);
    end
    a_req = 0; b_req = 0;
    @(posedge clk); #1;

    // B raised during A's ACCESS waits for the following IDLE edge.
    a_we = 1; a_size = 2'b10; a_addr = 12'h020; a_wdata = 32'hCAFE0123;
    a_req = 1;
    @(posedge clk); #1;
    b_we = 0; b_size = 2'b10; b_sign = 0; b_addr = 12'h020;
    b_req = 1;
    wait_done(6, who, n);
    chk("late_a_first", who, 32'd1);
    chk("late_a_lat", n, 32'd1);
    a_req = 0;
    wait_done(6, who, n);
    chk("late_b_second", who, 32'd2);
    chk("late_b_lat", n, 32'd3);
    chk("late_b_rdata", b_rdata, 32'hCAFE0123);
    b_req = 0;
    @(posedge clk); #1;

    // Reset during ACCESS drops the transaction silently.
    a_we = 0; a_size = 2'b10; a_addr = 12'h020;
    a_req = 1;
    @(posedge clk); #1;
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1; a_req = 0;
    chk_reset_outputs("rst_access");
    wait_done(4, who, n);
    chk("rst_no_done", who, 32'd0);

    // Reset during DONE: outputs clear on the next cycle.
    a_req = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rstd_done_seen", {31'b0, a_done}, 32'd1);
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1; a_req = 0;
    chk_reset_outputs("rst_done");

    // After reset, a tie goes to A again.
    a_req = 1; b_req = 1;
    wait_done(6, who, n);
    chk("post_rst_tie", who, 32'd1);
    a_req = 0; b_req = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Fixed priority instance: A wins every tie while it holds req.
    p_a_req = 1; p_b_req = 1;
    for (int k = 0; k < 3; k++) begin
      wait_done_p(8, who);
      chk($sformatf("fixed_grant%0d", k), who, 32'd1);
    end
    p_a_req = 0;
    wait_done_p(8, who);
    chk("fixed_b_after_a_drops", who, 32'd2);
    p_b_req = 0;
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
